ub_multitap_delay_buffer: RTL and testbench

//  Parametrised multi-tap delay-line buffer for unified-buffer stencil reads: one write port, NUM_TAPS read taps.

---
 rtl/ub_pkg.sv | 41 ++++
 rtl/ub_tap_addr_gen.sv | 34 +++
 rtl/ub_multitap_delay_buffer.sv | 127 ++++++++++++
 tb/tb_ub_multitap_delay_buffer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ub_pkg.sv
//------------------------------------------------------------------------------
// Module  : ub_pkg
// Brief   : Shared types and helpers for the unified-buffer multi-tap delay
//           line (delay/pointer containers, width helpers, modular subtract).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ub_pkg;

  // Delay registers are always 16 bits wide, independent of DEPTH.
  localparam int DELAY_W = 16;

  typedef logic [DELAY_W-1:0] delay_t;
  // Wide pointer container used for modular address arithmetic.
  typedef logic [DELAY_W-1:0] ptr_t;

  // Write-pointer width for a given storage depth.
  function automatic int calc_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Fill counter must be able to hold the value DEPTH itself.
  function automatic int calc_fill_w(input int depth);
    return calc_ptr_w(depth) + 1;
  endfunction

  // Tap-select width; never collapses to zero bits.
  function automatic int calc_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (ptr - d) mod depth for ptr < depth and d <= depth.  No power-of-two
  // assumption: the borrow case adds depth back explicitly.
  function automatic ptr_t mod_sub(input ptr_t ptr, input delay_t d, input ptr_t depth);
    return (ptr >= d) ? (ptr - d) : (ptr + (depth - d));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ub_tap_addr_gen.sv
//------------------------------------------------------------------------------
// Module  : ub_tap_addr_gen
// Brief   : Per-tap read address and valid generation.  A zero delay selects
//           the combinational bypass of the write port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ub_tap_addr_gen
  import ub_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int PTR_W  = 7,
  parameter int FILL_W = 8
) (
  input  logic [PTR_W-1:0]  wr_ptr,
  input  delay_t            delay,
  input  logic [FILL_W-1:0] fill_level,
  input  logic              in_valid,
  output logic [PTR_W-1:0]  rd_addr,
  output logic              valid,
  output logic              bypass
);

  // Address = slot written delay accepts ago; valid once that much history exists.
  always_comb begin
    rd_addr = PTR_W'(mod_sub(ptr_t'(wr_ptr), delay, ptr_t'(DEPTH)));
    bypass  = (delay == '0);
    valid   = bypass ? in_valid : (ptr_t'(fill_level) >= delay);
  end

endmodule

`default_nettype wire

// File: rtl/ub_multitap_delay_buffer.sv
//------------------------------------------------------------------------------
// Module  : ub_multitap_delay_buffer
// Brief   : Multi-tap delay line over one circular store.  Tap k returns the
//           sample accepted D_k accepts earlier; idle cycles freeze the line.
//           Optional macro UB_RUNTIME_DELAY_EN adds a runtime delay bank
//           (cfg_wen/cfg_tap/cfg_delay, sticky cfg_err).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ub_multitap_delay_buffer
  import ub_pkg::*;
#(
  parameter int                            DATA_W   = 16,
  parameter int                            NUM_TAPS = 4,
  parameter int                            DEPTH    = 128,
  parameter logic [NUM_TAPS*DELAY_W-1:0]   DELAYS   = {16'd3, 16'd2, 16'd66, 16'd67}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [DATA_W-1:0]              in_data,
  output logic [DATA_W-1:0]              tap_data [NUM_TAPS],
  output logic [NUM_TAPS-1:0]            tap_valid,
  output logic [calc_fill_w(DEPTH)-1:0]  fill_level
`ifdef UB_RUNTIME_DELAY_EN
  ,
  input  logic                           cfg_wen,
  input  logic [calc_sel_w(NUM_TAPS)-1:0] cfg_tap,
  input  logic [DELAY_W-1:0]             cfg_delay,
  output logic                           cfg_err
`endif
);

  localparam int PTR_W  = calc_ptr_w(DEPTH);
  localparam int FILL_W = calc_fill_w(DEPTH);

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  delay_t              delay [NUM_TAPS];
  logic [PTR_W-1:0]    rd_addr [NUM_TAPS];
  logic [NUM_TAPS-1:0] bypass;
  logic                accept;

  // Elaboration-time sanity checks on geometry and reset delays.
  if (DEPTH < 2 || DEPTH > 65535) begin : g_bad_depth
    $error("ub_multitap_delay_buffer: DEPTH must be in 2..65535");
  end
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_chk_delay
    if (32'(DELAYS[k*DELAY_W +: DELAY_W]) > 32'(DEPTH)) begin : g_bad_delay
      $error("ub_multitap_delay_buffer: DELAYS entry exceeds DEPTH");
    end
  end

  // Flush dominates: a flushed cycle never writes storage.
  assign accept = in_valid & ~flush;

  // Write pointer and saturating fill counter; flush restarts the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      fill_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      fill_level <= '0;
    end else if (in_valid) begin
      wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (fill_level != FILL_W'(DEPTH)) begin
        fill_level <= fill_level + 1'b1;
      end
    end
  end

  // Storage is never cleared; taps are qualified by tap_valid instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= in_data;
    end
  end

`ifdef UB_RUNTIME_DELAY_EN
  // Runtime delay bank: out-of-range delays clamp to DEPTH, bad taps are
  // dropped; both raise the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        delay[k] <= DELAYS[k*DELAY_W +: DELAY_W];
      end
      cfg_err <= 1'b0;
    end else if (cfg_wen) begin
      if (32'(cfg_tap) >= NUM_TAPS) begin
        cfg_err <= 1'b1;
      end else if (32'(cfg_delay) > 32'(DEPTH)) begin
        delay[cfg_tap] <= delay_t'(DEPTH);
        cfg_err        <= 1'b1;
      end else begin
        delay[cfg_tap] <= cfg_delay;
      end
    end
  end
`else
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_const_delay
    assign delay[k] = DELAYS[k*DELAY_W +: DELAY_W];
  end
`endif

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    ub_tap_addr_gen #(
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W),
      .FILL_W (FILL_W)
    ) u_addr (
      .wr_ptr     (wr_ptr),
      .delay      (delay[k]),
      .fill_level (fill_level),
      .in_valid   (in_valid),
      .rd_addr    (rd_addr[k]),
      .valid      (tap_valid[k]),
      .bypass     (bypass[k])
    );
    assign tap_data[k] = bypass[k] ? in_data : mem[rd_addr[k]];
  end

endmodule

`default_nettype wire

// File: tb/tb_ub_multitap_delay_buffer.sv
//------------------------------------------------------------------------------
// Module  : tb_ub_multitap_delay_buffer
// Brief   : Self-checking bench: two instances (default delays and
//           {128,1,0,3}) against a queue-based history model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ub_multitap_delay_buffer;
  import ub_pkg::*;

  localparam int DATA_W   = 16;
  localparam int NUM_TAPS = 4;
  localparam int DEPTH    = 128;
  localparam logic [63:0] DEL_A = {16'd3, 16'd2, 16'd66, 16'd67};
  localparam logic [63:0] DEL_B = {16'd3, 16'd0, 16'd1, 16'd128};

  logic clk, rst_n, flush, in_valid;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] tap_data_a [NUM_TAPS];
  logic [DATA_W-1:0] tap_data_b [NUM_TAPS];
  logic [NUM_TAPS-1:0] tap_valid_a, tap_valid_b;
  logic [7:0] fill_a, fill_b;
`ifdef UB_RUNTIME_DELAY_EN
  logic cfg_wen, cfg_wen_b;
  logic [1:0] cfg_tap;
  logic [15:0] cfg_delay;
  logic cfg_err_a, cfg_err_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  ub_multitap_delay_buffer #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS), .DEPTH(DEPTH), .DELAYS(DEL_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .tap_data(tap_data_a), .tap_valid(tap_valid_a), .fill_level(fill_a)
`ifdef UB_RUNTIME_DELAY_EN
    , .cfg_wen(cfg_wen), .cfg_tap(cfg_tap), .cfg_delay(cfg_delay), .cfg_err(cfg_err_a)
`endif
  );

  ub_multitap_delay_buffer #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS), .DEPTH(DEPTH), .DELAYS(DEL_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .tap_data(tap_data_b), .tap_valid(tap_valid_b), .fill_level(fill_b)
`ifdef UB_RUNTIME_DELAY_EN
    , .cfg_wen(cfg_wen_b), .cfg_tap(cfg_tap), .cfg_delay(cfg_delay), .cfg_err(cfg_err_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] hist[$];          // accepted samples since last restart, oldest first
  int unsigned acc_cnt = 0;      // accepts since last restart (unsaturated)
  int unsigned mdel [2][NUM_TAPS];
  bit merr [2];

  function automatic int unsigned def_delay(input int d, input int k);
    logic [63:0] dv;
    dv = (d == 0) ? DEL_A : DEL_B;
    return int'(dv[k*16 +: 16]);
  endfunction

  task automatic model_reset();
    hist.delete();
    acc_cnt = 0;
    for (int d = 0; d < 2; d++) begin
      merr[d] = 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) mdel[d][k] = def_delay(d, k);
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      if (flush) begin
        hist.delete();
        acc_cnt = 0;
      end else if (in_valid) begin
        hist.push_back(in_data);
        acc_cnt++;
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
`ifdef UB_RUNTIME_DELAY_EN
      if (cfg_wen) begin
        if (int'(cfg_tap) >= NUM_TAPS) merr[0] = 1'b1;
        else if (int'(cfg_delay) > DEPTH) begin
          mdel[0][cfg_tap] = DEPTH;
          merr[0] = 1'b1;
        end else mdel[0][cfg_tap] = int'(cfg_delay);
      end
`endif
    end
  end

  function automatic bit exp_valid(input int d, input int k);
    if (mdel[d][k] == 0) return in_valid;
    return acc_cnt >= mdel[d][k];
  endfunction

  function automatic logic [15:0] exp_data(input int d, input int k);
    if (mdel[d][k] == 0) return in_data;
    return hist[hist.size() - mdel[d][k]];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int unsigned ef;
        ef = (acc_cnt > DEPTH) ? DEPTH : acc_cnt;
        check($sformatf("fill[%0d]", d), 32'((d == 0) ? fill_a : fill_b), ef);
        for (int k = 0; k < NUM_TAPS; k++) begin
          bit av;
          logic [15:0] ad;
          av = (d == 0) ? tap_valid_a[k] : tap_valid_b[k];
          ad = (d == 0) ? tap_data_a[k] : tap_data_b[k];
          check($sformatf("valid[%0d][%0d]", d, k), 32'(av), 32'(exp_valid(d, k)));
          if (exp_valid(d, k)) check($sformatf("data[%0d][%0d]", d, k), 32'(ad), 32'(exp_data(d, k)));
        end
      end
`ifdef UB_RUNTIME_DELAY_EN
      check("cfg_err[0]", 32'(cfg_err_a), 32'(merr[0]));
      check("cfg_err[1]", 32'(cfg_err_b), 32'(merr[1]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [15:0] d, input bit f);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    flush    = f;
`ifdef UB_RUNTIME_DELAY_EN
    cfg_wen  = 1'b0;
`endif
  endtask

`ifdef UB_RUNTIME_DELAY_EN
  task automatic cfg(input logic [1:0] t, input logic [15:0] dl);
    cfg_wen   = 1'b1;
    cfg_tap   = t;
    cfg_delay = dl;
  endtask
`endif

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
`ifdef UB_RUNTIME_DELAY_EN
    cfg_wen = 1'b0; cfg_wen_b = 1'b0; cfg_tap = '0; cfg_delay = '0;
`endif
    #3 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    settle();
    check("rst fill_a", 32'(fill_a), 0);
    check("rst valid_a", 32'(tap_valid_a), 0);
    check("rst valid_b", 32'(tap_valid_b), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Ramp 0..99, then pin the model with hand-computed values.
    for (int k = 0; k < 100; k++) drive(1'b1, 16'(k), 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    settle();
    check("lit100 a tap0", 32'(tap_data_a[0]), 33);
    check("lit100 a tap1", 32'(tap_data_a[1]), 34);
    check("lit100 a tap2", 32'(tap_data_a[2]), 98);
    check("lit100 a tap3", 32'(tap_data_a[3]), 97);
    check("lit100 a valid", 32'(tap_valid_a), 32'hF);
    check("lit100 b tap1", 32'(tap_data_b[1]), 99);
    check("lit100 b valid", 32'(tap_valid_b), 32'hA);

    // Continue to 300 accepts: D=DEPTH tap and fill saturation.
    for (int k = 100; k < 300; k++) drive(1'b1, 16'(k), 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    settle();
    check("lit300 a tap0", 32'(tap_data_a[0]), 233);
    check("lit300 a tap1", 32'(tap_data_a[1]), 234);
    check("lit300 fill_a", 32'(fill_a), 128);
    check("lit300 b tap0", 32'(tap_data_b[0]), 172);
    check("lit300 fill_b", 32'(fill_b), 128);
    check("lit300 b valid", 32'(tap_valid_b), 32'hB);

    // Alternating valid, then random traffic with occasional flushes.
    for (int i = 0; i < 8; i++) drive(i % 2 == 0, 16'($urandom), 1'b0);
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 49) == 0);

    // 200 accepts, flush with in_valid high, then 0xABCD into slot 0.
    for (int i = 0; i < 200; i++) drive(1'b1, 16'($urandom), 1'b0);
    drive(1'b1, 16'h1111, 1'b1);
    drive(1'b1, 16'hABCD, 1'b0);
    settle();
    check("flush fill_a", 32'(fill_a), 0);
    check("flush fill_b", 32'(fill_b), 0);
    check("flush valid_a", 32'(tap_valid_a), 0);
    check("flush valid_b", 32'(tap_valid_b), 32'h4);
    check("flush b bypass", 32'(tap_data_b[2]), 32'hABCD);
    drive(1'b0, 16'h0, 1'b0);
    settle();
    check("abcd b tap1", 32'(tap_data_b[1]), 32'hABCD);
    check("abcd b valid", 32'(tap_valid_b), 32'h2);
    check("abcd fill_b", 32'(fill_b), 1);

`ifdef UB_RUNTIME_DELAY_EN
    drive(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 16'(1000 + i), 1'b0);
      if (i == 10) cfg(2'd1, 16'd5);
    end
    drive(1'b0, 16'h0, 1'b0);
    settle();
    check("cfg a tap1", 32'(tap_data_a[1]), 1025);
    check("cfg err0", 32'(cfg_err_a), 0);
    cfg(2'd0, 16'd500);
    drive(1'b0, 16'h0, 1'b0);
    settle();
    check("cfg err1", 32'(cfg_err_a), 1);
    drive(1'b1, 16'h5A5A, 1'b0);
    cfg(2'd0, 16'd0);
    drive(1'b1, 16'h1234, 1'b0);
    settle();
    check("cfg0 a data", 32'(tap_data_a[0]), 32'h1234);
    check("cfg0 a valid", 32'(tap_valid_a[0]), 1);
    drive(1'b0, 16'h4321, 1'b0);
    settle();
    check("cfg0 a idle valid", 32'(tap_valid_a[0]), 0);
    check("cfg0 a idle data", 32'(tap_data_a[0]), 32'h4321);
`endif

    // Asynchronous reset between clock edges, with in_valid still high.
    for (int i = 0; i < 50; i++) drive(1'b1, 16'(i), 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst fill_a", 32'(fill_a), 0);
    check("arst fill_b", 32'(fill_b), 0);
    check("arst valid_a", 32'(tap_valid_a), 0);
    check("arst valid_b", 32'(tap_valid_b & 4'b1011), 0);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 100; k++) drive(1'b1, 16'(k), 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    settle();
    check("post-rst a tap0", 32'(tap_data_a[0]), 33);
    check("post-rst a valid", 32'(tap_valid_a), 32'hF);
    check("post-rst b tap1", 32'(tap_data_b[1]), 99);

    drive(1'b0, 16'h0, 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
